// File: rtl/poly_note_gen.sv
// Multi-channel square-wave tone generator with saturated stereo/mono mixing.
// Each channel's note divisor is only adopted on a half-period boundary, so output edges stay glitch-free.
module poly_note_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 22,
  parameter int unsigned AUD_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mono,
  input  logic [NUM_CH*DIV_W-1:0]   note_div,
  input  logic [NUM_CH*AUD_W-1:0]   vol_up,
  input  logic [NUM_CH*AUD_W-1:0]   vol_down,
  output logic [NUM_CH-1:0]         ch_active,
  output logic [AUD_W-1:0]          audio_left,
  output logic [AUD_W-1:0]          audio_right
);

  localparam int unsigned SUM_W = AUD_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'({1'b0, {(AUD_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0]            ph_q, ph_d;
  logic [NUM_CH-1:0]            active_q, active_d;
  logic [AUD_W-1:0]             left_q, left_d;
  logic [AUD_W-1:0]             right_q, right_d;

  logic signed [AUD_W-1:0]      s_c [NUM_CH];
  logic signed [SUM_W-1:0]      sum_l, sum_r;

  function automatic logic [AUD_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[AUD_W-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[AUD_W-1:0];
    end
    return v[AUD_W-1:0];
  endfunction

  // Per-channel divider: rest reloads every cycle, otherwise reload only when the half-period ends.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    ph_d  = ph_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (div_q[c] == '0) begin
        cnt_d[c] = '0;
        ph_d[c]  = 1'b0;
        div_d[c] = note_div[c*DIV_W +: DIV_W];
      end else if (cnt_q[c] == div_q[c]) begin
        cnt_d[c] = '0;
        ph_d[c]  = ~ph_q[c];
        div_d[c] = note_div[c*DIV_W +: DIV_W];
      end else begin
        cnt_d[c] = cnt_q[c] + DIV_W'(1);
      end
    end
  end

  // Channel samples and full-precision mix; even channels go left, odd right unless mono.
  always_comb begin
    sum_l    = '0;
    sum_r    = '0;
    active_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      s_c[c]      = '0;
      active_d[c] = (div_q[c] != '0);
      if (div_q[c] != '0) begin
        s_c[c] = ph_q[c] ? vol_up[c*AUD_W +: AUD_W] : vol_down[c*AUD_W +: AUD_W];
      end
      if (mono || !c[0]) begin
        sum_l = sum_l + SUM_W'(s_c[c]);
      end
      if (mono || c[0]) begin
        sum_r = sum_r + SUM_W'(s_c[c]);
      end
    end
    left_d  = sat(sum_l);
    right_d = sat(sum_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= '0;
      ph_q     <= '0;
      active_q <= '0;
      left_q   <= '0;
      right_q  <= '0;
    end else if (en) begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      active_q <= active_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  assign ch_active   = active_q;
  assign audio_left  = left_q;
  assign audio_right = right_q;

endmodule
